// File: rtl/sr.sv
// Clocked NOR-style set/reset latch: combinational outputs over a stored bit
// that is captured on each rising clock edge.
module sr #(
    parameter logic RESET_Q = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic s,
    input  logic r,
    input  logic r2,
    output logic q,
    output logic q_bar
);

    logic hi;
    logic st_q;
    logic st_d;

    // Next stored value; a simultaneous set and clear leaves the bit untouched.
    always_comb begin
        hi   = r | r2;
        st_d = st_q;
        if (hi && !s) begin
            st_d = 1'b1;
        end else if (!hi && s) begin
            st_d = 1'b0;
        end
    end

    // Outputs track the inputs within the cycle; both go low on conflict.
    always_comb begin
        q     = st_q;
        q_bar = ~st_q;
        unique case ({hi, s})
            2'b10: begin
                q     = 1'b1;
                q_bar = 1'b0;
            end
            2'b01: begin
                q     = 1'b0;
                q_bar = 1'b1;
            end
            2'b11: begin
                q     = 1'b0;
                q_bar = 1'b0;
            end
            default: begin
                q     = st_q;
                q_bar = ~st_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q <= RESET_Q;
        end else begin
            st_q <= st_d;
        end
    end

endmodule

// File: tb/tb_sr.sv
// Directed bench for sr: one vector per clock cycle, outputs checked mid-cycle,
// plus a short sub-cycle pulse sequence.
module tb_sr;

    logic clock;
    logic reset;
    logic s;
    logic r;
    logic r2;
    logic q;
    logic q_bar;

    int checks;
    int errors;

    typedef struct {
        logic rst;
        logic s;
        logic r;
        logic r2;
        logic exp_q;
        logic exp_qb;
    } vec_t;

    vec_t vecs[$];

    sr #(.RESET_Q(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .s     (s),
        .r     (r),
        .r2    (r2),
        .q     (q),
        .q_bar (q_bar)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic si, input logic ri, input logic r2i,
                       input logic eq, input logic eqb);
        vec_t v;
        v.rst = rst; v.s = si; v.r = ri; v.r2 = r2i; v.exp_q = eq; v.exp_qb = eqb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic got_q, input logic got_qb,
                         input logic exp_q, input logic exp_qb);
        checks++;
        if (got_q !== exp_q || got_qb !== exp_qb) begin
            errors++;
            $display("FAIL %s: q/q_bar got %b/%b want %b/%b", name, got_q, got_qb, exp_q, exp_qb);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        s      = 1'b0;
        r      = 1'b0;
        r2     = 1'b0;

        //  rst s  r  r2   q  qb
        add(1, 1, 0, 0,   0, 1);   // reset edge while clearing
        add(0, 0, 0, 0,   0, 1);   // reset value held
        add(0, 0, 1, 0,   1, 0);   // set via r
        add(0, 0, 0, 0,   1, 0);   // held high
        add(0, 1, 0, 0,   0, 1);   // clear
        add(0, 0, 0, 0,   0, 1);   // held low
        add(0, 0, 0, 1,   1, 0);   // set via r2 only
        add(0, 0, 0, 0,   1, 0);   // held high
        add(0, 1, 1, 0,   0, 0);   // conflict, prior state 1
        add(0, 0, 0, 0,   1, 0);   // prior state restored
        add(0, 1, 0, 1,   0, 0);   // conflict using r2
        add(0, 0, 0, 0,   1, 0);
        add(0, 0, 1, 1,   1, 0);   // both set inputs
        add(0, 1, 0, 0,   0, 1);   // clear
        add(0, 1, 1, 1,   0, 0);   // conflict, prior state 0
        add(0, 0, 0, 0,   0, 1);   // prior state 0 restored
        add(0, 0, 1, 0,   1, 0);   // set
        add(1, 0, 0, 0,   1, 0);   // reset cycle: outputs still show hold
        add(0, 0, 0, 0,   0, 1);   // RESET_Q after reset edge
        add(1, 0, 1, 0,   1, 0);   // reset wins at edge, outputs follow r
        add(0, 0, 0, 0,   0, 1);
        add(0, 0, 1, 0,   1, 0);   // sequence: set
        add(0, 1, 0, 0,   0, 1);   //           clear
        add(0, 0, 0, 0,   0, 1);   //           hold
        add(0, 0, 1, 0,   1, 0);   //           set
        add(0, 0, 0, 0,   1, 0);   //           hold

        foreach (vecs[i]) begin
            @(posedge clock);
            #1;
            reset = vecs[i].rst;
            s     = vecs[i].s;
            r     = vecs[i].r;
            r2    = vecs[i].r2;
            @(negedge clock);
            check($sformatf("vec%0d", i), q, q_bar, vecs[i].exp_q, vecs[i].exp_qb);
        end

        // Clear the bit, then a set pulse that never spans a rising edge.
        @(posedge clock);
        #1;
        reset = 1'b0; s = 1'b1; r = 1'b0; r2 = 1'b0;
        @(posedge clock);
        #1;
        s = 1'b0;
        #1;
        check("pulse_pre", q, q_bar, 1'b0, 1'b1);
        r = 1'b1;
        #1;
        check("pulse_on", q, q_bar, 1'b1, 1'b0);
        r = 1'b0;
        #1;
        check("pulse_off", q, q_bar, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        check("pulse_not_kept", q, q_bar, 1'b0, 1'b1);

        // Short clear pulse over a held 1, also between edges.
        r2 = 1'b1;
        @(posedge clock);
        #1;
        r2 = 1'b0;
        #1;
        check("held_one", q, q_bar, 1'b1, 1'b0);
        s = 1'b1;
        #1;
        check("clr_pulse_on", q, q_bar, 1'b0, 1'b1);
        s = 1'b0;
        @(posedge clock);
        #1;
        check("clr_pulse_not_kept", q, q_bar, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
